// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the sum/latch/UART message path.
package sum_uart_pkg;

    localparam int unsigned OPND_W  = 4;
    localparam int unsigned SUM_W   = 5;
    localparam int unsigned MSG_LEN = 4;
    localparam int unsigned IDX_W   = 2;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StWaitAck,
        StWaitDone
    } seq_state_e;

    // Zero-extended operand addition; never overflows SUM_W.
    function automatic logic [SUM_W-1:0] opnd_sum(input logic [OPND_W-1:0] a,
                                                  input logic [OPND_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Byte idx of the message "<tens><ones>\r\n" for a sum in 0..30.
    function automatic logic [7:0] msg_byte(input logic [SUM_W-1:0] s,
                                            input logic [IDX_W-1:0] idx);
        logic [1:0] tens;
        logic [3:0] ones;
        logic [7:0] b;
        if (s >= 5'd30) begin
            tens = 2'd3;
            ones = 4'(s - 5'd30);
        end else if (s >= 5'd20) begin
            tens = 2'd2;
            ones = 4'(s - 5'd20);
        end else if (s >= 5'd10) begin
            tens = 2'd1;
            ones = 4'(s - 5'd10);
        end else begin
            tens = 2'd0;
            ones = 4'(s);
        end
        unique case (idx)
            2'd0: b = ASCII_ZERO + 8'(tens);
            2'd1: b = ASCII_ZERO + 8'(ones);
            2'd2: b = ASCII_CR;
            2'd3: b = ASCII_LF;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sum_msg_sequencer_if.sv
// Byte handshake between the message sequencer and the UART transmitter.
interface sum_msg_sequencer_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy
    );

endinterface

// File: rtl/button_conditioner.sv
// Synchronizer + debounce for an active-low button; emits a one-cycle pulse on an
// accepted press (1->0). Releases are debounced but produce no pulse.
module button_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   level_q, level_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    // Shift the raw level in; accept a new level after it has differed long enough.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_n};
        level_d = level_q;
        cnt_d   = '0;
        press   = 1'b0;
        if (synced != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = synced;
                press   = ~synced;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Released (1) is the reset level for both the synchronizer and debounced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '1;
            level_q <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sum_msg_sequencer.sv
// Latches operands A/B from debounced buttons and sends "<tens><ones>\r\n" of
// A+B to the UART transmitter, one byte per start/busy handshake.
module sum_msg_sequencer
    import sum_uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT     = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                save_a_n,
    input  logic                save_b_n,
    input  logic [OPND_W-1:0]   data_input,
    sum_msg_sequencer_if.master tx,
    output logic [OPND_W-1:0]   latched_a,
    output logic [OPND_W-1:0]   latched_b,
    output logic [SUM_W-1:0]    sum_out,
    output logic                seq_busy
);

    localparam int unsigned TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

    logic press_a, press_b;

    logic [OPND_W-1:0] din_meta_q, din_sync_q;
    logic [OPND_W-1:0] a_q, a_d, b_q, b_d;
    logic              pend_q, pend_d;
    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [SUM_W-1:0]  snap_q, snap_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              advance;

    button_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_a (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (save_a_n),
        .press   (press_a)
    );

    button_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_b (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_n   (save_b_n),
        .press   (press_b)
    );

    // Two-flop synchronizer for the operand bus; it settles long before a debounced press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            din_meta_q <= '0;
            din_sync_q <= '0;
        end else begin
            din_meta_q <= data_input;
            din_sync_q <= din_meta_q;
        end
    end

    // Operand latching, request queueing and the per-byte handshake FSM.
    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        pend_d    = pend_q;
        state_d   = state_q;
        idx_d     = idx_q;
        snap_d    = snap_q;
        tx_data_d = tx_data_q;
        tcnt_d    = tcnt_q;
        advance   = 1'b0;

        if (press_a) a_d = din_sync_q;
        if (press_b) begin
            b_d = din_sync_q;
            // Busy: remember one request; further presses collapse into it.
            if (state_q != StIdle) pend_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (press_b || pend_q) begin
                    state_d = StLoad;
                    pend_d  = 1'b0;
                    idx_d   = '0;
                    // Use this cycle's writes so a same-cycle A press is included.
                    snap_d  = opnd_sum(a_d, b_d);
                end
            end
            StLoad: begin
                tx_data_d = msg_byte(snap_q, idx_q);
                state_d   = StStart;
            end
            StStart: begin
                if (!tx.tx_busy) begin
                    state_d = StWaitAck;
                    tcnt_d  = '0;
                end
            end
            StWaitAck: begin
                if (tx.tx_busy) begin
                    state_d = StWaitDone;
                end else if (tcnt_q == TO_MAX) begin
                    // Transmitter never acknowledged; drop the byte and move on.
                    advance = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx.tx_busy) advance = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (advance) begin
            if (idx_q == LAST_IDX) begin
                state_d = StIdle;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = StLoad;
            end
        end
    end

    // State registers; reset abandons any message in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q       <= '0;
            b_q       <= '0;
            pend_q    <= 1'b0;
            state_q   <= StIdle;
            idx_q     <= '0;
            snap_q    <= '0;
            tx_data_q <= '0;
            tcnt_q    <= '0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            pend_q    <= pend_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            tx_data_q <= tx_data_d;
            tcnt_q    <= tcnt_d;
        end
    end

    // tx_start is one cycle long: START is left on the same edge it is asserted.
    assign tx.tx_start = (state_q == StStart) && !tx.tx_busy;
    assign tx.tx_data  = tx_data_q;
    assign latched_a   = a_q;
    assign latched_b   = b_q;
    assign sum_out     = opnd_sum(a_q, b_q);
    assign seq_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_sum_msg_sequencer.sv
// Scoreboard bench for sum_msg_sequencer: stimulus pushes expected bytes, a
// monitor pops and compares on every tx_start.
module tb_sum_msg_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       save_a_n;
    logic       save_b_n;
    logic [3:0] data_input;
    logic [3:0] latched_a;
    logic [3:0] latched_b;
    logic [4:0] sum_out;
    logic       seq_busy;

    sum_msg_sequencer_if bus();

    sum_msg_sequencer #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (16),
        .ACK_TIMEOUT     (255)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .save_a_n   (save_a_n),
        .save_b_n   (save_b_n),
        .data_input (data_input),
        .tx         (bus),
        .latched_a  (latched_a),
        .latched_b  (latched_b),
        .sum_out    (sum_out),
        .seq_busy   (seq_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int start_cnt = 0;
    int start_cyc[$];
    logic [7:0] exp_q[$];
    bit ack_en   = 1'b1;
    int busy_len = 20;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transmitter model: busy rises one cycle after start and holds busy_len cycles.
    initial begin
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && bus.tx_start === 1'b1) begin
                @(posedge clk);
                #1 bus.tx_busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1 bus.tx_busy = 1'b0;
            end
        end
    end

    // Monitor: every tx_start must match the head of the expected queue.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                start_cnt++;
                start_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("tx_start_unexpected", int'(bus.tx_start), 0);
                end else begin
                    check("tx_byte", int'(bus.tx_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push_msg(input logic [7:0] t, input logic [7:0] o);
        exp_q.push_back(t);
        exp_q.push_back(o);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic press(input bit is_b, input logic [3:0] d);
        data_input = d;
        repeat (4) @(posedge clk);
        #1;
        if (is_b) save_b_n = 1'b0;
        else      save_a_n = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        save_a_n = 1'b1;
        save_b_n = 1'b1;
        repeat (24) @(posedge clk);
        #1;
    endtask

    task automatic bounce(input bit is_b, input logic [3:0] d);
        data_input = d;
        repeat (4) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            if (is_b) save_b_n = 1'b0;
            else      save_a_n = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            save_a_n = 1'b1;
            save_b_n = 1'b1;
            repeat (5) @(posedge clk);
        end
        repeat (30) @(posedge clk);
        #1;
    endtask

    // Wait for seq_busy to stay low for 8 cycles, bounded by budget.
    task automatic wait_idle(input string name, input int budget);
        int quiet = 0;
        int n = 0;
        while (quiet < 8 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (seq_busy) quiet = 0;
            else quiet++;
        end
        check(name, int'(quiet >= 8), 1);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        reset_n    = 1'b0;
        save_a_n   = 1'b1;
        save_b_n   = 1'b1;
        data_input = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_start", int'(bus.tx_start), 0);
        check("rst_tx_data", int'(bus.tx_data), 0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_latched_a", int'(latched_a), 0);
        check("rst_latched_b", int'(latched_b), 0);
        check("rst_sum_out", int'(sum_out), 0);
        check("rst_seq_busy", int'(seq_busy), 0);
        repeat (1000) @(posedge clk);
        #1;
        check("idle_no_start", start_cnt, 0);
        check("idle_seq_busy", int'(seq_busy), 0);

        // 7 + 8 = 15 -> "15\r\n"
        press(1'b0, 4'd7);
        check("a_7", int'(latched_a), 7);
        push_msg(8'h31, 8'h35);
        press(1'b1, 4'd8);
        check("b_8", int'(latched_b), 8);
        check("sum_15", int'(sum_out), 15);
        check("busy_msg1", int'(seq_busy), 1);
        wait_idle("msg_15", 1000);

        // 15 + 15 = 30 -> "30\r\n"
        press(1'b0, 4'd15);
        push_msg(8'h33, 8'h30);
        press(1'b1, 4'd15);
        check("sum_30", int'(sum_out), 30);
        wait_idle("msg_30", 1000);

        // 0 + 0 -> "00\r\n"
        press(1'b0, 4'd0);
        push_msg(8'h30, 8'h30);
        press(1'b1, 4'd0);
        check("sum_0", int'(sum_out), 0);
        wait_idle("msg_00", 1000);

        // Glitches shorter than the debounce window are ignored.
        bounce(1'b0, 4'd9);
        check("bounce_a", int'(latched_a), 0);
        bounce(1'b1, 4'd9);
        check("bounce_b", int'(latched_b), 0);
        check("bounce_no_msg", int'(seq_busy), 0);
        base = start_cnt;
        push_msg(8'h30, 8'h33);
        press(1'b1, 4'd3);
        wait_idle("msg_03", 1000);
        repeat (200) @(posedge clk);
        #1;
        check("held_one_msg", start_cnt - base, 4);

        // Presses during a message: snapshot holds, one queued follow-up message.
        busy_len = 60;
        press(1'b0, 4'd7);
        push_msg(8'h31, 8'h35);
        push_msg(8'h30, 8'h36);
        base = start_cnt;
        press(1'b1, 4'd8);
        press(1'b0, 4'd2);
        press(1'b1, 4'd4);
        press(1'b1, 4'd4);
        check("pend_busy", int'(seq_busy), 1);
        wait_idle("msg_pending", 3000);
        repeat (300) @(posedge clk);
        #1;
        check("pend_two_msgs", start_cnt - base, 8);
        check("pend_a", int'(latched_a), 2);
        check("pend_sum", int'(sum_out), 6);
        busy_len = 20;

        // No acknowledgement: each byte abandoned after the timeout.
        ack_en = 1'b0;
        base = start_cyc.size();
        push_msg(8'h30, 8'h37);
        press(1'b1, 4'd5);
        wait_idle("msg_timeout", 2000);
        if (start_cyc.size() >= base + 2)
            check("timeout_gap", start_cyc[base+1] - start_cyc[base], 257);
        else
            check("timeout_starts", start_cyc.size() - base, 4);

        // Reset asserted while tx_start is high.
        exp_q.push_back(8'h30);
        base = start_cnt;
        press(1'b1, 4'd4);
        n = 0;
        while (start_cnt == base && n < 400) begin
            @(posedge clk);
            n++;
        end
        n = 0;
        @(posedge clk);
        #1;
        while (bus.tx_start !== 1'b1 && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_start_seen", int'(bus.tx_start), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_tx_start", int'(bus.tx_start), 0);
        check("mid_rst_busy", int'(seq_busy), 0);
        check("mid_rst_a", int'(latched_a), 0);
        base = start_cnt;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        check("post_rst_no_start", start_cnt - base, 0);
        check("post_rst_idle", int'(seq_busy), 0);
        check("post_rst_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sum_msg_sequencer.md
Name: sum_msg_sequencer

Overview:
- Sits between the operand-latch front end and the UART transmitter inside the sum/latch/UART system.
- Conditions the two active-low save buttons and latches the 4-bit operands A and B.
- On a save_b event, forms the 5-bit sum A+B and transmits it as a 4-byte ASCII message: tens digit, ones digit, CR, LF.
- Feeds the transmitter one byte at a time over a start/busy handshake.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on each button input (minimum 2).
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a button level is accepted.
- ACK_TIMEOUT, 255, cycles to wait for tx_busy to rise after tx_start before abandoning the byte.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- save_a_n  in  1  asynchronous active-low button; a press latches operand A.
- save_b_n  in  1  asynchronous active-low button; a press latches operand B and requests a message.
- data_input  in  4  operand value, sampled through the same sync delay as the buttons.
- tx_busy  in  1  UART transmitter busy flag.
- tx_start  out  1  one-cycle pulse requesting transmission of tx_data.
- tx_data  out  8  byte to send; valid while tx_start is high and held until the next load.
- latched_a  out  4  current operand A.
- latched_b  out  4  current operand B.
- sum_out  out  5  latched_a + latched_b, combinational from the registers.
- seq_busy  out  1  high from message accept until the final LF completes.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; pending flag 0; debounced button levels 1 (released).
- Clock and reset: single clock; reset is asynchronous assert, synchronous release through the flops' normal clocking.
- Button conditioning:
  - Synchronize each button through SYNC_STAGES flops.
  - Debounce counter resets on any level change; the new level is accepted when the counter reaches DEBOUNCE_CYCLES-1.
  - Accepting a 1->0 transition emits a one-cycle press pulse. Releases emit nothing.
- data_input path: synchronized in a 2-flop register; operands are taken from this synchronized copy.
- press_a: latched_a <= synced data_input on the pulse cycle. Allowed at any time, including mid-message.
- press_b: latched_b <= synced data_input. If the FSM is IDLE, start a message. Otherwise set the pending flag; it holds at most one request and extra presses are absorbed.
- Same-cycle press_a and press_b: both registers update. The message uses the new values.
- Snapshot:
  - On message start (IDLE->LOAD), capture s = latched_a + latched_b using the values written that cycle.
  - Message digits come from the snapshot only; later press_a events do not alter an in-flight message.
- Digit rules: s ranges 0..30. tens = 3/2/1/0 for s >= 30 / >= 20 / >= 10 / else; ones = s - 10*tens. ASCII byte = 0x30 + digit. Leading zero is always sent (s=5 -> "05").
- FSM states: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE.
  - IDLE -> LOAD on a start request or a pending flag (pending is cleared on that transition).
  - LOAD: tx_data <= byte[idx], with idx starting at 0; then go to START.
  - START: only when tx_busy=0, assert tx_start for exactly one cycle and go to WAIT_ACK. If tx_busy=1, stay.
  - WAIT_ACK: tx_busy=1 -> WAIT_DONE. If ACK_TIMEOUT cycles elapse, treat the byte as sent (go to the advance step).
  - WAIT_DONE: on tx_busy=0, advance. If idx=3 -> IDLE; otherwise idx++ and go to LOAD.
- Latency: press_b pulse to first tx_start is 2 cycles when tx_busy=0.
- seq_busy = (state != IDLE).
- Reset mid-message: the message is abandoned and tx_start drops immediately. No resend after reset release.

Decomposition:
- Shared package sum_uart_pkg:
  - State enum.
  - MSG_LEN=4.
  - ASCII_ZERO=8'h30, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - Operand width 4 and sum width 5.
- Sub-module button_conditioner (synchronizer + debounce + falling-edge pulse), instantiated twice.

Test Plan:
- Reset with both buttons released -> all outputs 0, seq_busy=0, no tx_start for 1000 cycles.
- data_input=7, press A; data_input=8, press B; tx model asserts busy 1 cycle after start for 20 cycles -> bytes 0x31, 0x35, 0x0D, 0x0A in order, sum_out=15, seq_busy falls after LF.
- A=15, B=15 -> "30\r\n" (0x33, 0x30); A=0, B=0 -> "00\r\n".
- Button bouncing 5-cycle glitches shorter than DEBOUNCE_CYCLES -> no latch and no message; a held press -> exactly one message.
- During message 1, press A with data 2 then press B twice -> message 1 digits unchanged; exactly one further message carrying the new sum.
- tx_busy held 0 (no ack) -> each byte advances after ACK_TIMEOUT cycles; reset_n low mid-byte -> tx_start=0, FSM idle, no further bytes.
